// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI memory-slave front end.
//   - Default widths for the received command word and the returned read byte.
//   - Receive/transmit FSM state encoding.
//   - Two-bit command codes carried in bits [9:8] of every received word.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_WORD_W = 10;
    localparam int SPI_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_out.sv
// -----------------------------------------------------------------------------
// spi_shift_out
// Parallel-load, MSB-first serialiser that drives the MISO line.
// Ports:
//   clk_i    : clock, output bit changes on the rising edge
//   rst_i    : synchronous active-high reset
//   clear_i  : abandon any transfer in progress and force the output low
//   load_i   : capture data_i and launch its MSB on the same edge (when idle)
//   data_i   : byte to serialise
//   bit_o    : serial output, low whenever no transfer is in progress
//   busy_o   : a transfer is in progress (load_i is ignored while high)
//   done_o   : the next edge launches the final (LSB) bit
// -----------------------------------------------------------------------------
module spi_shift_out
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              bit_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     left_q, left_d;
    logic              busy_q, busy_d;
    logic              bit_q, bit_d;

    // Next-state logic. The MSB is launched on the load edge itself, so the
    // shift register only keeps the bits still to be sent and left_q counts
    // them down. Once it reaches zero the line returns low on the next edge.
    always_comb begin
        shreg_d = shreg_q;
        left_d  = left_q;
        busy_d  = busy_q;
        bit_d   = bit_q;
        if (clear_i) begin
            shreg_d = '0;
            left_d  = '0;
            busy_d  = 1'b0;
            bit_d   = 1'b0;
        end else if (busy_q) begin
            if (left_q != '0) begin
                bit_d   = shreg_q[DATA_W-1];
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                left_d  = left_q - CW'(1);
            end else begin
                bit_d  = 1'b0;
                busy_d = 1'b0;
            end
        end else if (load_i) begin
            bit_d   = data_i[DATA_W-1];
            shreg_d = {data_i[DATA_W-2:0], 1'b0};
            left_d  = CW'(DATA_W - 1);
            busy_d  = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            left_q  <= '0;
            busy_q  <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            left_q  <= left_d;
            busy_q  <= busy_d;
            bit_q   <= bit_d;
        end
    end

    assign bit_o  = bit_q;
    assign busy_o = busy_q;
    assign done_o = busy_q && !clear_i && (left_q == CW'(1));

endmodule

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// Serial front end of the SPI memory slave. Assembles MOSI frames into
// {cmd[1:0], payload[7:0]} words for the RAM and serialises the RAM's read
// byte back out on MISO. One bit per clk, no oversampling.
// Ports:
//   clk      : SPI clock; MOSI sampled and MISO updated on the rising edge
//   rst      : synchronous active-high reset
//   SS_n     : active-low slave select; high ends or aborts the frame
//   MOSI     : serial data in, MSB first
//   MISO     : serial data out, MSB first
//   rx_data  : assembled command word to the RAM
//   rx_valid : one-cycle strobe qualifying rx_data
//   tx_data  : read byte from the RAM
//   tx_valid : strobe qualifying tx_data
// -----------------------------------------------------------------------------
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int WORD_W = SPI_WORD_W,
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    // After CHK_CMD takes the first bit, the remaining WORD_W-1 bits are
    // counted here; reaching this value means the word is complete.
    localparam logic [3:0] LAST_CNT = 4'(WORD_W - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_done_q, rx_done_d;
    logic              rd_addr_seen_q, rd_addr_seen_d;
    logic              tx_taken_q, tx_taken_d;

    logic              tx_load;
    logic              tx_busy;
    logic              tx_done;

    // Next-state and datapath control. SS_n high wins over everything except
    // reset: the frame is dropped, partial words are discarded and MISO is
    // forced low through the serialiser's clear. rx_done_q keeps a frame to a
    // single strobe; tx_taken_q keeps a read frame to a single byte latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_done_d      = rx_done_q;
        rd_addr_seen_d = rd_addr_seen_q;
        tx_taken_d     = tx_taken_q;
        tx_load        = 1'b0;

        if (SS_n) begin
            state_d    = IDLE;
            cnt_d      = '0;
            rx_done_d  = 1'b0;
            tx_taken_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CHK_CMD;
                    cnt_d   = '0;
                    shift_d = '0;
                end
                CHK_CMD: begin
                    shift_d    = {shift_q[WORD_W-2:0], MOSI};
                    cnt_d      = '0;
                    rx_done_d  = 1'b0;
                    tx_taken_d = 1'b0;
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (!rd_addr_seen_q) begin
                        state_d = READ_ADD;
                    end else begin
                        state_d = READ_DATA;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!rx_done_q) begin
                        if (cnt_q != LAST_CNT) begin
                            shift_d = {shift_q[WORD_W-2:0], MOSI};
                            cnt_d   = cnt_q + 4'd1;
                        end else begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            rx_done_d  = 1'b1;
                            if (state_q == READ_ADD) begin
                                rd_addr_seen_d = 1'b1;
                            end
                        end
                    end else if (state_q == READ_DATA) begin
                        if (tx_valid && !tx_taken_q && !tx_busy) begin
                            tx_load    = 1'b1;
                            tx_taken_d = 1'b1;
                        end
                        if (tx_done) begin
                            rd_addr_seen_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_done_q      <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_taken_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_done_q      <= rx_done_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            tx_taken_q     <= tx_taken_d;
        end
    end

    spi_shift_out #(
        .DATA_W (DATA_W)
    ) u_shift_out (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (SS_n),
        .load_i  (tx_load),
        .data_i  (tx_data),
        .bit_o   (MISO),
        .busy_o  (tx_busy),
        .done_o  (tx_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_if
// Directed bench for spi_slave_if. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the DUT's
// rising-edge update.
// -----------------------------------------------------------------------------
module tb_spi_slave_if;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int checkCount = 0;
    int failCount  = 0;
    int rxPulses   = 0;

    spi_slave_if dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    // Tally every rx_valid strobe so each scenario can count pulses per frame.
    always @(posedge clk) begin
        if (rx_valid === 1'b1) rxPulses++;
    end

    // Open a frame and shift the top n bits of w, MSB first. Returns on the
    // falling edge just after the last bit has been sampled.
    task automatic sendBits(input logic [9:0] w, input int n);
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            MOSI = w[9-i];
        end
        @(negedge clk);
    endtask

    // Close the frame; returns one cycle after SS_n has been seen high.
    task automatic endFrame;
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        SS_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            MOSI = ~MOSI;
            checkCount++;
            if (MISO !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL reset_miso cyc=%0d got=%b exp=0", i, MISO);
            end
            checkCount++;
            if (rx_valid !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL reset_rx_valid cyc=%0d got=%b exp=0", i, rx_valid);
            end
            checkCount++;
            if (rx_data !== 10'h000) begin
                failCount++;
                $display("[TB] FAIL reset_rx_data cyc=%0d got=%h exp=000", i, rx_data);
            end
            checkCount++;
            if (dut.state_q !== IDLE) begin
                failCount++;
                $display("[TB] FAIL reset_state cyc=%0d got=%0d exp=%0d", i, dut.state_q, IDLE);
            end
        end
        rst  = 1'b0;
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_addr;
        int p0;
        p0 = rxPulses;
        sendBits(10'h0A5, 10);
        checkCount++;
        if (rx_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL wr_addr_early got=%b exp=0", rx_valid);
        end
        @(negedge clk);
        checkCount++;
        if (rx_valid !== 1'b1 || rx_data !== 10'h0A5) begin
            failCount++;
            $display("[TB] FAIL wr_addr_word got=%b/%h exp=1/0a5", rx_valid, rx_data);
        end
        @(negedge clk);
        checkCount++;
        if (rx_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL wr_addr_strobe_width got=%b exp=0", rx_valid);
        end
        for (int i = 0; i < 12; i++) begin
            MOSI = (i % 3 != 0);
            @(negedge clk);
        end
        endFrame();
        checkCount++;
        if (rxPulses - p0 !== 1) begin
            failCount++;
            $display("[TB] FAIL wr_addr_pulses got=%0d exp=1", rxPulses - p0);
        end
        checkCount++;
        if (dut.state_q !== IDLE) begin
            failCount++;
            $display("[TB] FAIL wr_addr_idle got=%0d exp=%0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_write_data_read_addr;
        int p0;
        sendBits(10'h13C, 10);
        @(negedge clk);
        checkCount++;
        if (rx_valid !== 1'b1 || rx_data !== 10'h13C) begin
            failCount++;
            $display("[TB] FAIL wr_data_word got=%b/%h exp=1/13c", rx_valid, rx_data);
        end
        endFrame();
        p0 = rxPulses;
        sendBits(10'h2A5, 10);
        checkCount++;
        if (dut.state_q !== READ_ADD) begin
            failCount++;
            $display("[TB] FAIL rd_addr_state got=%0d exp=%0d", dut.state_q, READ_ADD);
        end
        @(negedge clk);
        checkCount++;
        if (rx_valid !== 1'b1 || rx_data !== 10'h2A5) begin
            failCount++;
            $display("[TB] FAIL rd_addr_word got=%b/%h exp=1/2a5", rx_valid, rx_data);
        end
        checkCount++;
        if (dut.rd_addr_seen_q !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL rd_addr_seen_set got=%b exp=1", dut.rd_addr_seen_q);
        end
        repeat (4) @(negedge clk);
        endFrame();
        checkCount++;
        if (rxPulses - p0 !== 1) begin
            failCount++;
            $display("[TB] FAIL rd_addr_pulses got=%0d exp=1", rxPulses - p0);
        end
    endtask

    task automatic test_read_data;
        logic [7:0] misoExp;
        misoExp = 8'b0011_1100;
        sendBits(10'h355, 10);
        checkCount++;
        if (dut.state_q !== READ_DATA) begin
            failCount++;
            $display("[TB] FAIL rd_data_state got=%0d exp=%0d", dut.state_q, READ_DATA);
        end
        @(negedge clk);
        checkCount++;
        if (rx_valid !== 1'b1 || rx_data[9:8] !== 2'b11 || rx_data !== 10'h355) begin
            failCount++;
            $display("[TB] FAIL rd_data_word got=%b/%h exp=1/355", rx_valid, rx_data);
        end
        repeat (2) @(negedge clk);
        checkCount++;
        if (MISO !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rd_data_wait_miso got=%b exp=0", MISO);
        end
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        checkCount++;
        if (MISO !== misoExp[7]) begin
            failCount++;
            $display("[TB] FAIL rd_data_bit7 got=%b exp=%b", MISO, misoExp[7]);
        end
        for (int i = 6; i >= 0; i--) begin
            if (i == 4) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end else begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
            @(negedge clk);
            checkCount++;
            if (MISO !== misoExp[i]) begin
                failCount++;
                $display("[TB] FAIL rd_data_bit%0d got=%b exp=%b", i, MISO, misoExp[i]);
            end
        end
        checkCount++;
        if (dut.rd_addr_seen_q !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rd_addr_seen_clear got=%b exp=0", dut.rd_addr_seen_q);
        end
        @(negedge clk);
        checkCount++;
        if (MISO !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rd_data_tail_miso got=%b exp=0", MISO);
        end
        endFrame();
    endtask

    task automatic test_abort;
        int p0;
        p0 = rxPulses;
        sendBits(10'h0F0, 6);
        endFrame();
        repeat (3) @(negedge clk);
        checkCount++;
        if (rxPulses - p0 !== 0) begin
            failCount++;
            $display("[TB] FAIL abort_pulses got=%0d exp=0", rxPulses - p0);
        end
        checkCount++;
        if (dut.state_q !== IDLE) begin
            failCount++;
            $display("[TB] FAIL abort_state got=%0d exp=%0d", dut.state_q, IDLE);
        end
        sendBits(10'h001, 10);
        @(negedge clk);
        checkCount++;
        if (rx_valid !== 1'b1 || rx_data !== 10'h001) begin
            failCount++;
            $display("[TB] FAIL abort_next_word got=%b/%h exp=1/001", rx_valid, rx_data);
        end
        endFrame();
    endtask

    task automatic test_read_no_addr;
        int highs;
        highs = 0;
        sendBits(10'h203, 10);
        checkCount++;
        if (dut.state_q !== READ_ADD) begin
            failCount++;
            $display("[TB] FAIL noaddr_state got=%0d exp=%0d", dut.state_q, READ_ADD);
        end
        @(negedge clk);
        checkCount++;
        if (rx_valid !== 1'b1 || rx_data !== 10'h203) begin
            failCount++;
            $display("[TB] FAIL noaddr_word got=%b/%h exp=1/203", rx_valid, rx_data);
        end
        for (int i = 0; i < 10; i++) begin
            tx_valid = (i < 3);
            tx_data  = 8'hFF;
            @(negedge clk);
            if (MISO !== 1'b0) highs++;
        end
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        checkCount++;
        if (highs !== 0) begin
            failCount++;
            $display("[TB] FAIL noaddr_miso_quiet got=%0d high cycles exp=0", highs);
        end
        endFrame();
    endtask

    task automatic test_mid_reset;
        sendBits(10'h0FF, 10);
        @(negedge clk);
        checkCount++;
        if (rx_data !== 10'h0FF) begin
            failCount++;
            $display("[TB] FAIL midrst_pre_word got=%h exp=0ff", rx_data);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            MOSI = ~MOSI;
            @(negedge clk);
        end
        checkCount++;
        if (rx_data !== 10'h000 || rx_valid !== 1'b0 || MISO !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midrst_outputs got=%h/%b/%b exp=000/0/0", rx_data, rx_valid, MISO);
        end
        checkCount++;
        if (dut.state_q !== IDLE || dut.rd_addr_seen_q !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midrst_state got=%0d/%b exp=%0d/0", dut.state_q, dut.rd_addr_seen_q, IDLE);
        end
        rst  = 1'b0;
        SS_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        test_reset();
        test_write_addr();
        test_write_data_read_addr();
        test_read_data();
        test_abort();
        test_read_no_addr();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front end for the on-chip SPI memory slave; sits directly upstream of the 256x8 RAM.
- Deserialises MOSI frames into 10-bit command words {cmd[1:0], payload[7:0]} and presents each with a one-cycle rx_valid strobe to the RAM.
- Captures the RAM's read byte (tx_data/tx_valid) and serialises it MSB-first onto MISO.
- One bit per clk; clk is the SPI clock domain, with no oversampling.

Parameters:
- WORD_W, 10, width of rx_data (2 command bits + 8 payload bits).
- DATA_W, 8, width of the read byte returned on MISO.

Ports:
- clk  input  1  single clock; MOSI sampled and MISO updated on rising edge.
- rst  input  1  synchronous, active-high reset.
- SS_n  input  1  slave select, active low; a high level ends or aborts the frame.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  10  assembled command word to RAM (RAM din).
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  8  read byte from RAM.
- tx_valid  input  1  RAM strobe, tx_data valid.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - MISO=0, rx_data=0, rx_valid=0.
  - Bit counter=0, shift registers=0, rd_addr_seen=0.
  - rst overrides every other input.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD. Otherwise remain.
- CHK_CMD:
  - Sample MOSI as bit 9 of the word and shift it in.
  - MOSI=0 -> WRITE (cmd 00/01).
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD (cmd 10).
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA (cmd 11).
- WRITE / READ_ADD / READ_DATA receive phase:
  - Shift 9 more MOSI bits MSB-first (bits 8..0).
  - The 10th bit is sampled in the 9th cycle after CHK_CMD.
  - On the following edge, rx_data <= assembled word and rx_valid=1 for exactly one cycle.
  - Latency: rx_valid rises one clk after the last bit is sampled.
- Command bits are forwarded unmodified; bits[9:8] are not re-checked against the state.
- After rx_valid:
  - WRITE: hold, ignore MOSI until SS_n=1.
  - READ_ADD: set rd_addr_seen=1 in the same cycle as rx_valid, then hold until SS_n=1.
  - READ_DATA:
    - Wait for tx_valid; latch tx_data on the edge where tx_valid=1.
    - Drive MISO = tx_data[7] starting the next cycle, then bits 6..0 on successive cycles (8 cycles total).
    - Clear rd_addr_seen when bit 0 is driven.
    - MISO=0 afterwards.
- SS_n=1 in any non-IDLE state:
  - Next state is IDLE, the counter clears, MISO=0.
  - No rx_valid for a partial word.
  - rd_addr_seen is kept unless the READ_DATA transfer completed.
- SS_n=1 in the same cycle the 10th bit would be sampled: the bit is not taken and no rx_valid is issued.
- tx_valid outside READ_DATA is ignored. A tx_valid pulse during MISO shifting is ignored (no re-latch).
- tx_valid never arrives: hold in READ_DATA with MISO=0 until SS_n=1.
- rx_valid is never asserted for two consecutive cycles. At most one rx_valid per SS_n frame.
- Bit counter is 4 bits, counts 0..9, and is cleared on every state entry (no wrap).

Decomposition:
- Shared package spi_pkg:
  - State encoding constants (IDLE=0, CHK_CMD=1, WRITE=2, READ_ADD=3, READ_DATA=4).
  - Command codes (CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11).
  - WORD_W and DATA_W defaults.
- One natural sub-module, spi_shift_out: 8-bit parallel-load, MSB-first shifter with load, busy and done.
- FSM, receive shifter and counter stay in spi_slave_if.

Test Plan:
- Reset: assert rst with SS_n=0 and MOSI toggling -> MISO=0, rx_valid=0, rx_data=0, state IDLE; hold for 3 cycles.
- Write address: SS_n=0, send 00_1010_0101 -> single rx_valid with rx_data=10'h0A5, one clk after the 10th bit; no further rx_valid until SS_n toggles.
- Write data: send 01_0011_1100 -> rx_valid with rx_data=10'h13C. Then read address 10_1010_0101 -> rx_data=10'h2A5 and rd_addr_seen=1.
- Read data: send 11_xxxx_xxxx -> rx_valid with rx_data[9:8]=2'b11; RAM returns tx_valid with tx_data=8'h3C -> MISO = 0,0,1,1,1,1,0,0 on the next 8 cycles; rd_addr_seen=0 afterwards.
- Abort: deassert SS_n after 6 bits of 00_1111_0000 -> no rx_valid, state IDLE. The next full frame 00_0000_0001 -> rx_data=10'h001.
- Read with no prior address: first frame starts with bit 1 while rd_addr_seen=0 -> FSM enters READ_ADD (not READ_DATA); tx_valid pulses are ignored; MISO stays 0.
